// File: rtl/exec_alu_sequencer.sv
// Multi-cycle execute-stage controller: steers shared-ALU operand selects per
// instruction class, latches results/branch outcome and runs the memory handshake.
module exec_alu_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [2:0]  op_class,
  input  logic [31:0] alu_result,
  input  logic        cmp_true,
  input  logic        mem_ack,
  output logic        sig_aluregsrc,
  output logic        sig_aluimmsrc,
  output logic        mem_req,
  output logic [31:0] result,
  output logic [31:0] target,
  output logic        taken,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PASS1, S_PASS2, S_MEM_WAIT, S_DONE
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_I, CLS_AUIPC, CLS_LDST, CLS_BRANCH, CLS_JAL, CLS_JALR, CLS_ILLEGAL
  } cls_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t            state_q, state_d;
  cls_t              class_q, class_d;
  logic [31:0]       result_q, result_d;
  logic [31:0]       target_q, target_d;
  logic              taken_q, taken_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      class_q  <= CLS_R;
      result_q <= '0;
      target_q <= '0;
      taken_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      class_q  <= class_d;
      result_q <= result_d;
      target_q <= target_d;
      taken_q  <= taken_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    class_d  = class_q;
    result_d = result_q;
    target_d = target_q;
    taken_d  = taken_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_valid) begin
          class_d = cls_t'(op_class);
          if (cls_t'(op_class) == CLS_ILLEGAL) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_PASS1;
          end
        end
      end
      S_PASS1: begin
        result_d = alu_result;
        err_d    = 1'b0;
        case (class_q)
          CLS_BRANCH: begin
            taken_d = cmp_true;
            state_d = S_PASS2;
          end
          CLS_JAL, CLS_JALR: begin
            target_d = alu_result;
            taken_d  = 1'b1;
            state_d  = S_DONE;
          end
          CLS_LDST: begin
            cnt_d   = '0;
            taken_d = 1'b0;
            state_d = S_MEM_WAIT;
          end
          default: begin
            taken_d = 1'b0;
            state_d = S_DONE;
          end
        endcase
      end
      S_PASS2: begin
        // target is captured regardless of outcome; taken qualifies it
        target_d = alu_result;
        state_d  = S_DONE;
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sig_aluregsrc = 1'b0;
    sig_aluimmsrc = 1'b0;
    case (state_q)
      S_PASS1: begin
        case (class_q)
          CLS_I, CLS_LDST, CLS_JALR: sig_aluimmsrc = 1'b1;
          CLS_AUIPC, CLS_JAL: begin
            sig_aluregsrc = 1'b1;
            sig_aluimmsrc = 1'b1;
          end
          default: ;
        endcase
      end
      S_PASS2: begin
        sig_aluregsrc = 1'b1;
        sig_aluimmsrc = 1'b1;
      end
      default: ;
    endcase
    start_ready = (state_q == S_IDLE);
    mem_req     = (state_q == S_MEM_WAIT);
    done        = (state_q == S_DONE);
  end

  assign result = result_q;
  assign target = target_q;
  assign taken  = taken_q;
  assign err    = err_q;

endmodule

// File: tb/tb_exec_alu_sequencer.sv
// Directed bench for exec_alu_sequencer with immediate-assertion checks.
module tb_exec_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid;
  logic        start_ready;
  logic [2:0]  op_class;
  logic [31:0] alu_result;
  logic        cmp_true;
  logic        mem_ack;
  logic        sig_aluregsrc;
  logic        sig_aluimmsrc;
  logic        mem_req;
  logic [31:0] result;
  logic [31:0] target;
  logic        taken;
  logic        done;
  logic        err;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  exec_alu_sequencer #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .op_class(op_class), .alu_result(alu_result), .cmp_true(cmp_true),
    .mem_ack(mem_ack),
    .sig_aluregsrc(sig_aluregsrc), .sig_aluimmsrc(sig_aluimmsrc),
    .mem_req(mem_req), .result(result), .target(target), .taken(taken),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sel(input string tag, input logic r, input logic i);
    chk({tag, "_regsrc"}, {31'd0, sig_aluregsrc}, {31'd0, r});
    chk({tag, "_immsrc"}, {31'd0, sig_aluimmsrc}, {31'd0, i});
  endtask

  task automatic issue(input logic [2:0] cls);
    start_valid = 1'b1;
    op_class    = cls;
    tick();
    start_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start_valid = 1'b0; op_class = 3'd0;
    alu_result = '0; cmp_true = 1'b0; mem_ack = 1'b0;
    #1;
    chk("rst_ready", {31'd0, start_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_memreq", {31'd0, mem_req}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_target", target, 32'd0);
    chk("rst_taken_err", {30'd0, taken, err}, 32'd0);
    sel("rst", 1'b0, 1'b0);
    @(negedge clk); rst = 1'b0;
    tick();

    // JAL: PC/IMM, target and taken set, done at T+2
    issue(3'd5);
    sel("jal_p1", 1'b1, 1'b1);
    chk("jal_p1_ready", {31'd0, start_ready}, 32'd0);
    chk("jal_p1_done", {31'd0, done}, 32'd0);
    alu_result = 32'h0000_0080;
    tick();
    chk("jal_done", {31'd0, done}, 32'd1);
    chk("jal_target", target, 32'h80);
    chk("jal_result", result, 32'h80);
    chk("jal_taken", {31'd0, taken}, 32'd1);
    tick();
    chk("jal_idle_done", {31'd0, done}, 32'd0);

    // BRANCH taken: RS1/RS2 then PC/IMM, done at T+3
    issue(3'd4);
    sel("br_p1", 1'b0, 1'b0);
    cmp_true = 1'b1; alu_result = 32'h0000_0055;
    tick();
    sel("br_p2", 1'b1, 1'b1);
    chk("br_p2_done", {31'd0, done}, 32'd0);
    cmp_true = 1'b0; alu_result = 32'h0000_0100;
    tick();
    chk("br_done", {31'd0, done}, 32'd1);
    chk("br_taken", {31'd0, taken}, 32'd1);
    chk("br_target", target, 32'h100);
    chk("br_result", result, 32'h55);
    tick();

    // BRANCH not taken: target still written
    issue(3'd4);
    cmp_true = 1'b0; alu_result = 32'h0000_0033;
    tick();
    alu_result = 32'h0000_0200;
    tick();
    chk("brn_done", {31'd0, done}, 32'd1);
    chk("brn_taken", {31'd0, taken}, 32'd0);
    chk("brn_target", target, 32'h200);
    tick();

    // LDST, ack on the 4th wait cycle (the timeout cycle: ack wins)
    issue(3'd3);
    sel("ld_p1", 1'b0, 1'b1);
    alu_result = 32'h0000_2000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("ld_memreq%0d", i), {31'd0, mem_req}, 32'd1);
      chk($sformatf("ld_done%0d", i), {31'd0, done}, 32'd0);
      if (i == 1) sel("ld_wait", 1'b0, 1'b0);
      if (i == 4) mem_ack = 1'b1;
      tick();
    end
    mem_ack = 1'b0;
    chk("ld_done", {31'd0, done}, 32'd1);
    chk("ld_err", {31'd0, err}, 32'd0);
    chk("ld_result", result, 32'h2000);
    chk("ld_memreq_off", {31'd0, mem_req}, 32'd0);
    tick();

    // LDST timeout: 4 wait cycles, then done with err
    issue(3'd3);
    alu_result = 32'h0000_3000;
    tick();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_memreq%0d", i), {31'd0, mem_req}, 32'd1);
      tick();
    end
    chk("to_done", {31'd0, done}, 32'd1);
    chk("to_err", {31'd0, err}, 32'd1);
    chk("to_memreq_off", {31'd0, mem_req}, 32'd0);
    tick();
    chk("to_err_hold", {31'd0, err}, 32'd1);

    // R-type clears taken/err
    issue(3'd0);
    sel("r_p1", 1'b0, 1'b0);
    alu_result = 32'h0000_0007;
    tick();
    chk("r_done", {31'd0, done}, 32'd1);
    chk("r_result", result, 32'h7);
    chk("r_taken", {31'd0, taken}, 32'd0);
    chk("r_err", {31'd0, err}, 32'd0);
    chk("r_ready", {31'd0, start_ready}, 32'd0);
    tick();
    chk("r_idle_ready", {31'd0, start_ready}, 32'd1);

    // AUIPC selects
    issue(3'd2);
    sel("auipc_p1", 1'b1, 1'b1);
    tick(); tick();

    // Illegal: done at T+1 with err, no ALU pass
    issue(3'd7);
    chk("ill_done", {31'd0, done}, 32'd1);
    chk("ill_err", {31'd0, err}, 32'd1);
    sel("ill", 1'b0, 1'b0);
    tick();
    chk("ill_idle_done", {31'd0, done}, 32'd0);

    // start_valid held while busy is taken only once back in IDLE
    start_valid = 1'b1; op_class = 3'd1;
    tick();
    sel("hold_p1", 1'b0, 1'b1);
    op_class = 3'd0; alu_result = 32'h0000_0011;
    tick();
    chk("hold_done", {31'd0, done}, 32'd1);
    chk("hold_result", result, 32'h11);
    tick();
    chk("hold_idle_ready", {31'd0, start_ready}, 32'd1);
    tick();
    start_valid = 1'b0;
    sel("hold_p1b", 1'b0, 1'b0);
    alu_result = 32'h0000_0022;
    tick();
    chk("hold_done2", {31'd0, done}, 32'd1);
    chk("hold_result2", result, 32'h22);
    tick();

    // Async reset during MEM_WAIT
    issue(3'd3);
    alu_result = 32'h0000_4000;
    tick();
    chk("rmw_memreq", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rmw_memreq_off", {31'd0, mem_req}, 32'd0);
    chk("rmw_ready", {31'd0, start_ready}, 32'd1);
    chk("rmw_done", {31'd0, done}, 32'd0);
    chk("rmw_result", result, 32'd0);
    @(negedge clk); rst = 1'b0;
    tick();
    chk("rmw_post_ready", {31'd0, start_ready}, 32'd1);
    chk("rmw_post_done", {31'd0, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_alu_sequencer.md
Name: exec_alu_sequencer

Overview:
- Multi-cycle execute-stage controller that sequences the shared ALU and its operand selectors, one instruction at a time.
- For each instruction class it drives the op1 select (RS1/PC) and op2 select (RS2/IMM) for one or two ALU passes.
- It latches ALU results and branch decisions, and holds a memory handshake for load/store.
- Sits between decode (valid/ready issue) and writeback/fetch redirect (done pulse plus latched results).

Parameters:
- MEM_TIMEOUT, 255: max cycles in MEM_WAIT before err is raised; range 1..255.
- CNT_W, 8: width of the memory-wait counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start_valid  in  1  decode presents an instruction
- start_ready  out  1  sequencer can accept; equals (state==IDLE)
- op_class  in  3  0 R, 1 I, 2 AUIPC, 3 LDST, 4 BRANCH, 5 JAL, 6 JALR, 7 illegal; sampled on accept
- alu_result  in  32  shared ALU output, combinational from current selects
- cmp_true  in  1  branch comparator outcome for current rs1/rs2
- mem_ack  in  1  memory completes request
- sig_aluregsrc  out  1  0=ALUREGSRC_RS1, 1=ALUREGSRC_PC
- sig_aluimmsrc  out  1  0=ALUIMMSRC_RS2, 1=ALUIMMSRC_IMM
- mem_req  out  1  memory request, high throughout MEM_WAIT
- result  out  32  latched pass-1 ALU result (data, address, or JAL/JALR target)
- target  out  32  latched redirect target
- taken  out  1  redirect required
- done  out  1  one-cycle completion pulse
- err  out  1  qualified by done: illegal class or memory timeout

Behaviour:
- Reset (async, any state): state=IDLE; class_q=0; result, target=0; taken, done, err, mem_req=0; counter=0; selects=0/0.
- Accept: start_valid && start_ready at edge T → class_q=op_class, state=PASS1 at T+1. Class 7 goes to DONE with err=1 instead.
- Selects are combinational from state and class_q; IDLE/DONE/MEM_WAIT drive 0/0.
- PASS1 selects:
  - R: RS1/RS2
  - I, LDST, JALR: RS1/IMM
  - AUIPC, JAL: PC/IMM
  - BRANCH: RS1/RS2
- End of PASS1 edge: result<=alu_result. Then:
  - BRANCH: taken<=cmp_true; go PASS2.
  - JAL/JALR: target<=alu_result, taken<=1; go DONE.
  - LDST: counter<=0; go MEM_WAIT.
  - Others: taken<=0; go DONE.
- PASS2 (BRANCH only): selects PC/IMM; target<=alu_result at edge; go DONE. target is written even when not taken; taken is the qualifier.
- MEM_WAIT: mem_req=1.
  - mem_ack → DONE, err=0.
  - Else counter++; counter reaching MEM_TIMEOUT-1 without ack → DONE, err=1.
  - ack on the timeout cycle wins, err=0.
- DONE: done=1 for exactly one cycle; next state IDLE; start_ready=0 in DONE, so back-to-back accept is earliest at IDLE.
- Latency from accept edge T to done asserted:
  - R/I/AUIPC/JAL/JALR: T+2
  - BRANCH: T+3
  - LDST: T+3+wait cycles
  - illegal: T+1
- result, target, taken, err hold until overwritten by the next instruction; they are not cleared in IDLE.
- Reset mid-operation aborts it: no done; mem_req drops immediately (async).
- start_valid while busy is ignored, not queued.
- Arithmetic: 32-bit pass-through latching only; counter saturates, no wrap.

Test Plan:
- R-type: op_class=0, alu_result=0x0000_0007 during PASS1 → selects 0/0 in PASS1, done at T+2, result=7, taken=0, err=0.
- BRANCH taken: op_class=4, cmp_true=1 in PASS1, alu_result=0x100 in PASS2 → PASS1 selects 0/0, PASS2 selects 1/1, done at T+3, taken=1, target=0x100.
- LDST with ack after 3 wait cycles: alu_result=0x2000 → mem_req high 4 cycles, result=0x2000, done at T+6, err=0; second case with MEM_TIMEOUT=4 and no ack → done with err=1 after 4 MEM_WAIT cycles, mem_req then 0.
- Illegal class 7 → done at T+1, err=1, no ALU pass (selects stay 0/0).
- Reset asserted asynchronously during MEM_WAIT → mem_req and state cleared same cycle, no done, start_ready=1 after reset release; start_valid held during busy accepted only once back in IDLE.
